tram_arbiter: RTL and testbench
===============================

TRAM_ARBITER -- requirements
Module: tram_arbiter

Interface
REQ-001 SHALL have parameter DW, default 16: RAM data width in bits.
REQ-002 SHALL have parameter AW, default 4: RAM address width in bits (depth 2**AW).
REQ-003 SHALL have parameter NREQ, default 3: number of requesters, range 2..8.
REQ-004 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-005 SHALL have port sys_rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester access request.
REQ-007 SHALL have port req_ready  output  NREQ  one-hot grant, at most one bit set.
REQ-008 SHALL have port req_we  input  NREQ  per-requester write flag (1=write, 0=read).
REQ-009 SHALL have port req_addr  input  NREQ*AW  flattened addresses; requester i at bits [i*AW +: AW].
REQ-010 SHALL have port req_din  input  NREQ*DW  flattened write data; requester i at bits [i*DW +: DW].
REQ-011 SHALL have port rsp_valid  output  NREQ  one-hot read-data strobe.
REQ-012 SHALL have port rsp_dout  output  DW  read data, qualified by rsp_valid.
REQ-013 SHALL have ports ram_en, ram_we (output 1), ram_addr (output AW), ram_din (output DW) and ram_dout (input DW): the single-port RAM interface, with read data registered one cycle after en&!we.

Function
REQ-014 SHALL compute the grant combinationally each cycle from req_valid and the priority pointer; req_ready[i] is 1 only if req_valid[i] is 1.
REQ-015 SHALL treat the handshake req_valid[i]&req_ready[i] as an accepted access, issued to the RAM in that same cycle.
REQ-016 SHALL drive ram_en=1 and ram_we/ram_addr/ram_din from the granted requester's fields when a grant exists; otherwise ram_en=0, ram_we=0, ram_addr=0, ram_din=0.
REQ-017 SHALL, for an accepted read by requester i at cycle t, assert rsp_valid[i] at cycle t+1 only, with rsp_dout=ram_dout.
REQ-018 SHALL hold rsp_valid at 0 after accepted writes and idle cycles; rsp_dout SHALL be 0 whenever rsp_valid is 0.
REQ-019 SHALL sustain one access per cycle; back-to-back reads produce back-to-back responses, in order.
REQ-020 SHALL keep the priority pointer ptr (width clog2(NREQ)) unchanged on cycles with no grant.
REQ-021 SHALL scan requesters starting at ptr upward, wrapping from NREQ-1 to 0, and grant the first valid one.
REQ-022 SHALL require requesters to hold req_we/addr/din stable while valid&!ready; a requester SHALL be allowed to drop valid before grant.
REQ-023 SHALL order a write at cycle t before a read at t+1 to the same address, so the read returns the new data.

Reset
REQ-024 SHALL, while sys_rst_n=0, force ptr=0, rsp_valid=0, rsp_dout=0 and the response-tag register to 0, asynchronously.
REQ-025 SHALL drop any read response pending at reset assertion; no rsp_valid SHALL appear after reset release for it.
REQ-026 SHALL derive ram_* outputs combinationally, so they are 0 under reset because no grant exists while req_valid is gated by reset.

Configuration
REQ-027 SHALL, with TRAM_ARB_RR_EN defined, set ptr to (granted index + 1) mod NREQ after each grant, giving round-robin.
REQ-028 SHALL, without TRAM_ARB_RR_EN, hold ptr at 0 permanently, giving fixed priority with index 0 highest.

Structure
REQ-029 SHALL place in the shared package tram_arb_pkg: the default DW/AW/NREQ constants and the function computing the pointer width.
REQ-030 SHALL contain a single sub-module rr_grant (NREQ-wide rotate-and-priority-encode, one-hot output plus index); the RAM is instantiated outside this block.

Verification
REQ-031 SHALL cover this scenario: req 0 writes 0x1234 to addr 5, then reads addr 5 on the next cycle -> rsp_valid=3'b001 two cycles after the write, rsp_dout=0x1234.
REQ-032 SHALL cover this scenario: RR on, all three valid for 6 cycles -> grants 0,1,2,0,1,2.
REQ-033 SHALL cover this scenario: RR off, all three valid for 3 cycles -> requester 0 granted every cycle; 1 and 2 remain ready=0.
REQ-034 SHALL cover this scenario: requester 2 reads addr 0xF at cycle t, requester 1 reads addr 0x3 at t+1 -> rsp_valid 3'b100 at t+1, then 3'b010 at t+2, with correct data.
REQ-035 SHALL cover this scenario: assert sys_rst_n=0 in the cycle after an accepted read -> rsp_valid stays 0; after release, ptr=0 and first grant goes to the lowest valid index.
REQ-036 SHALL cover this scenario: no valid for 4 cycles -> ram_en=0, req_ready=0, rsp_valid=0, ptr unchanged.

Source files
------------

// File: rtl/tram_arb_pkg.sv
// Shared constants and helpers for the tram_arbiter RAM arbiter.
package tram_arb_pkg;

    localparam int TRAM_DW_DEF   = 16;
    localparam int TRAM_AW_DEF   = 4;
    localparam int TRAM_NREQ_DEF = 3;

    // Width of the priority pointer; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tram_arbiter_rr_grant.sv
// rr_grant: scans requesters from ptr_i upward with wrap-around and returns
// the first valid one as a one-hot grant plus its index.
module rr_grant #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  valid_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int   j;
        logic found;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && valid_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = PW'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/tram_arbiter.sv
// tram_arbiter: NREQ requesters share one single-port RAM, one access per cycle.
// Define TRAM_ARB_RR_EN for round-robin; otherwise fixed priority (index 0 highest).
module tram_arbiter
    import tram_arb_pkg::*;
#(
    parameter int DW   = TRAM_DW_DEF,
    parameter int AW   = TRAM_AW_DEF,
    parameter int NREQ = TRAM_NREQ_DEF
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_din,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_dout,
    output logic               ram_en,
    output logic               ram_we,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_din,
    input  logic [DW-1:0]      ram_dout
);

    localparam int PW = ptr_width(NREQ);

    logic [NREQ-1:0] valid_gated;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gidx;
    logic            gany;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] tag_q, tag_d;

    // Gating by reset keeps the RAM port quiet while reset is held.
    assign valid_gated = sys_rst_n ? req_valid : '0;

    rr_grant #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr_grant (
        .valid_i (valid_gated),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gidx),
        .any_o   (gany)
    );

    assign req_ready = grant;

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        tag_d    = '0;
        ptr_d    = ptr_q;
        if (gany) begin
            ram_en   = 1'b1;
            ram_we   = req_we[gidx];
            ram_addr = req_addr[gidx*AW +: AW];
            ram_din  = req_din[gidx*DW +: DW];
            if (!req_we[gidx]) begin
                tag_d = grant;
            end
        end
`ifdef TRAM_ARB_RR_EN
        if (gany) begin
            ptr_d = (int'(gidx) == NREQ - 1) ? '0 : gidx + PW'(1);
        end
`else
        ptr_d = '0;
`endif
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ptr_q <= '0;
            tag_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            tag_q <= tag_d;
        end
    end

    // The tag marks which requester owns the RAM read data arriving this cycle.
    assign rsp_valid = tag_q;
    assign rsp_dout  = (|tag_q) ? ram_dout : '0;

endmodule

// File: tb/tb_tram_arbiter.sv
// Self-checking bench for tram_arbiter with a behavioural RAM and reference model.
// Expectations follow TRAM_ARB_RR_EN when it is defined for the build.
module tb_tram_arbiter;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int N  = 3;

    logic            clk = 1'b0;
    logic            sys_rst_n;
    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_din;
    logic [DW-1:0]   rsp_dout, ram_din, ram_dout;
    logic            ram_en, ram_we;
    logic [AW-1:0]   ram_addr;

    int checks = 0;
    int errors = 0;

    tram_arbiter #(.DW(DW), .AW(AW), .NREQ(N)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_din(req_din),
        .rsp_valid(rsp_valid), .rsp_dout(rsp_dout),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [2**AW];
    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    // Reference model state
    int            mptr;
    logic [DW-1:0] shadow [2**AW];
    logic [N-1:0]  pend_v;
    logic [DW-1:0] pend_d;
`ifdef TRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int ref_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int cur_grant();
        if (!sys_rst_n) return -1;
        return ref_grant(req_valid, mptr);
    endfunction

    task automatic model_reset();
        mptr   = 0;
        pend_v = '0;
        pend_d = '0;
    endtask

    task automatic model_compare(input string tag);
        int g;
        g = cur_grant();
        chk({tag, ".ready"}, 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
        chk({tag, ".ram_en"}, 32'(ram_en), 32'(g >= 0));
        chk({tag, ".ram_we"}, 32'(ram_we), (g >= 0) ? 32'(req_we[g]) : 32'd0);
        chk({tag, ".ram_addr"}, 32'(ram_addr), (g >= 0) ? 32'(req_addr[g*AW +: AW]) : 32'd0);
        chk({tag, ".ram_din"}, 32'(ram_din), (g >= 0) ? 32'(req_din[g*DW +: DW]) : 32'd0);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(pend_v));
        chk({tag, ".rsp_dout"}, 32'(rsp_dout), 32'(pend_d));
    endtask

    task automatic model_commit();
        int            g;
        logic [AW-1:0] a;
        g = cur_grant();
        pend_v = '0;
        pend_d = '0;
        if (!sys_rst_n) begin
            mptr = 0;
        end else if (g >= 0) begin
            a = req_addr[g*AW +: AW];
            if (req_we[g]) begin
                shadow[a] = req_din[g*DW +: DW];
            end else begin
                pend_v = N'(1 << g);
                pend_d = shadow[a];
            end
            if (RR) mptr = (g + 1) % N;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_check(input string tag);
        #1;
        model_compare(tag);
        model_commit();
        tick();
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_din[i*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        @(negedge clk);
        sys_rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  we;
        logic [N-1:0]  exp_ready;
        logic          exp_en;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_din;
        logic [N-1:0]  exp_rsp;
    } vec_t;

    vec_t vecs [8];
    logic [N-1:0] held;

    initial begin
        for (int i = 0; i < 2**AW; i++) shadow[i] = '0;
        req_valid = '0; req_we = '0; req_addr = '0; req_din = '0;
        sys_rst_n = 1'b0;
        model_reset();
        #2;
        req_valid = '1;
        #1;
        chk("reset.ready", 32'(req_ready), 32'd0);
        chk("reset.ram_en", 32'(ram_en), 32'd0);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.rsp_dout", 32'(rsp_dout), 32'd0);
        req_valid = '0;
        do_reset();

        // Table vectors, each from a fresh reset so ptr starts at 0.
        // Requester i uses addr 8+i and data A0A0+i.
        vecs[0] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 4'h0, 16'h0000, 3'b000};
        vecs[1] = '{3'b001, 3'b000, 3'b001, 1'b1, 1'b0, 4'h8, 16'hA0A0, 3'b001};
        vecs[2] = '{3'b110, 3'b010, 3'b010, 1'b1, 1'b1, 4'h9, 16'hA0A1, 3'b000};
        vecs[3] = '{3'b100, 3'b000, 3'b100, 1'b1, 1'b0, 4'hA, 16'hA0A2, 3'b100};
        vecs[4] = '{3'b111, 3'b110, 3'b001, 1'b1, 1'b0, 4'h8, 16'hA0A0, 3'b001};
        vecs[5] = '{3'b011, 3'b001, 3'b001, 1'b1, 1'b1, 4'h8, 16'hA0A0, 3'b000};
        vecs[6] = '{3'b101, 3'b100, 3'b001, 1'b1, 1'b0, 4'h8, 16'hA0A0, 3'b001};
        vecs[7] = '{3'b110, 3'b000, 3'b010, 1'b1, 1'b0, 4'h9, 16'hA0A1, 3'b010};
        for (int v = 0; v < 8; v++) begin
            do_reset();
            for (int i = 0; i < N; i++)
                set_req(i, vecs[v].valid[i], vecs[v].we[i], AW'(8 + i), DW'(16'hA0A0 + i));
            #1;
            chk($sformatf("vec%0d.ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
            chk($sformatf("vec%0d.ram_en", v), 32'(ram_en), 32'(vecs[v].exp_en));
            chk($sformatf("vec%0d.ram_we", v), 32'(ram_we), 32'(vecs[v].exp_we));
            chk($sformatf("vec%0d.ram_addr", v), 32'(ram_addr), 32'(vecs[v].exp_addr));
            chk($sformatf("vec%0d.ram_din", v), 32'(ram_din), 32'(vecs[v].exp_din));
            model_commit();
            tick();
            req_valid = '0;
            #1;
            chk($sformatf("vec%0d.rsp_valid", v), 32'(rsp_valid), 32'(vecs[v].exp_rsp));
        end

        // Write then read same address on the next cycle.
        do_reset();
        set_req(0, 1'b1, 1'b1, 4'h5, 16'h1234);
        cycle_check("wr_rd.wr");
        set_req(0, 1'b1, 1'b0, 4'h5, 16'h0000);
        cycle_check("wr_rd.rd");
        req_valid = '0;
        #1;
        chk("wr_rd.rsp_valid", 32'(rsp_valid), 32'h1);
        chk("wr_rd.rsp_dout", 32'(rsp_dout), 32'h1234);
        cycle_check("wr_rd.tail");

        // All three valid for six cycles.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, AW'(i), DW'(i));
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("all_valid.c%0d", c), 32'(req_ready), RR ? 32'(1 << (c % 3)) : 32'h1);
            cycle_check($sformatf("all_valid.m%0d", c));
        end
        req_valid = '0;

        // Back-to-back reads from different requesters.
        set_req(2, 1'b1, 1'b1, 4'hF, 16'hBEEF);
        cycle_check("b2b.pre2");
        req_valid = '0;
        set_req(1, 1'b1, 1'b1, 4'h3, 16'h0333);
        cycle_check("b2b.pre1");
        req_valid = '0;
        set_req(2, 1'b1, 1'b0, 4'hF, 16'h0);
        cycle_check("b2b.rd2");
        req_valid = '0;
        set_req(1, 1'b1, 1'b0, 4'h3, 16'h0);
        #1;
        chk("b2b.rsp_valid2", 32'(rsp_valid), 32'b100);
        chk("b2b.rsp_dout2", 32'(rsp_dout), 32'hBEEF);
        cycle_check("b2b.rd1");
        req_valid = '0;
        #1;
        chk("b2b.rsp_valid1", 32'(rsp_valid), 32'b010);
        chk("b2b.rsp_dout1", 32'(rsp_dout), 32'h0333);
        cycle_check("b2b.tail");

        // Reset right after an accepted read drops the response.
        set_req(1, 1'b1, 1'b0, 4'h3, 16'h0);
        cycle_check("rst_rd.rd");
        req_valid = '0;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_rd.rsp_valid0", 32'(rsp_valid), 32'd0);
        chk("rst_rd.rsp_dout0", 32'(rsp_dout), 32'd0);
        tick();
        chk("rst_rd.rsp_valid1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        sys_rst_n = 1'b1;
        tick();
        chk("rst_rd.rsp_valid2", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(i), 16'h0);
        #1;
        chk("rst_rd.first_grant", 32'(req_ready), 32'b001);
        cycle_check("rst_rd.after");
        req_valid = '0;

        // Idle cycles leave the pointer alone.
        do_reset();
        set_req(1, 1'b1, 1'b1, 4'h7, 16'h7777);
        cycle_check("idle.pre");
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("idle.en%0d", c), 32'(ram_en), 32'd0);
            chk($sformatf("idle.ready%0d", c), 32'(req_ready), 32'd0);
            chk($sformatf("idle.rsp%0d", c), 32'(rsp_valid), 32'd0);
            cycle_check($sformatf("idle.m%0d", c));
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, AW'(i), 16'h0);
        #1;
        chk("idle.ptr_kept", 32'(req_ready), RR ? 32'b100 : 32'b001);
        cycle_check("idle.after");
        req_valid = '0;

        // Randomised traffic; a waiting requester holds its fields or withdraws.
        held = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (held[i]) begin
                    req_valid[i] = ($urandom_range(7) != 0);
                end else begin
                    set_req(i, $urandom_range(1) == 1, $urandom_range(1) == 1,
                            AW'($urandom_range(2**AW - 1)), DW'($urandom));
                end
            end
            #1;
            held = req_valid & ~req_ready;
            cycle_check($sformatf("rand%0d", c));
        end
        req_valid = '0;
        cycle_check("rand.drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
